imm_encoder: RTL

- Inverse of the immediate-extension path in the multi-cycle core. Takes an 8-bit immediate plus an immsrc selector and packs it into an 18-bit instruction word.
- Merges the packed immediate with a caller-supplied base word and flags any immediate that cannot be encoded.
- Results pass through a small registered output FIFO with valid/ready handshakes on both sides.
- Used by the instruction-memory loader / self-test path to build instructions whose decode reproduces the requested immediate.

---
 rtl/imm_encoder.sv | 102 ++++++++++
 1 files changed

// File: rtl/imm_encoder.sv
// Packs an 8-bit immediate into an 18-bit instruction word (inverse of immediate extension)
// and queues the result, with its encodability flag, in a small registered output FIFO.
module imm_encoder #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_base,
  input  logic [1:0]       in_immsrc,
  input  logic [7:0]       in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [17:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    SRC_LOW_A  = 2'b00,
    SRC_LOW_B  = 2'b01,
    SRC_BRANCH = 2'b10,
    SRC_NONE   = 2'b11
  } immsrc_e;

  immsrc_e     src;
  logic [17:0] enc_instr;
  logic        enc_err;

  logic [18:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [18:0]   head;
  logic          push;
  logic          pop;

  assign src = immsrc_e'(in_immsrc);

  // Branch form keeps only imm[7:2]; imm[7] lands in the sign bit, imm[6:2] in the low field.
  always_comb begin
    enc_instr = in_base;
    enc_err   = 1'b0;
    case (src)
      SRC_LOW_A, SRC_LOW_B: enc_instr = {in_base[17:8], in_imm};
      SRC_BRANCH: begin
        enc_instr = {in_imm[7], in_base[16:5], in_imm[6:2]};
        enc_err   = |in_imm[1:0];
      end
      default: enc_err = 1'b1;
    endcase
  end

  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~reset;
  assign pop       = out_valid & out_ready & ~reset;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {enc_err, enc_instr};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_count <= '0;
      err_count  <= '0;
    end else if (push) begin
      if (word_count != '1)          word_count <= word_count + CNT_W'(1);
      if (enc_err && err_count != '1) err_count <= err_count + CNT_W'(1);
    end
  end

  // Stale storage is hidden: the head reads as zero whenever the FIFO is empty.
  assign head      = mem[rd_ptr];
  assign out_instr = out_valid ? head[17:0] : '0;
  assign out_err   = out_valid ? head[18]   : 1'b0;

endmodule
